// File: rtl/regfile_rename.sv
// Architectural register file with per-register busy bit and producer ROB tag.
// Reads are combinational and include a same-cycle commit bypass.
module regfile_rename #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int REG_ID_BIT = 5,
    parameter int ROB_BIT    = 4,
    parameter int NRD        = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      reorder_en,
    input  logic [REG_ID_BIT-1:0]     reorder_reg,
    input  logic [ROB_BIT-1:0]        reorder_id,
    input  logic                      write_en,
    input  logic [REG_ID_BIT-1:0]     reg_id,
    input  logic [ROB_BIT-1:0]        rob_id,
    input  logic [XLEN-1:0]           value,
    input  logic [NRD*REG_ID_BIT-1:0] rs,
    output logic [NRD-1:0]            rs_busy,
    output logic [NRD*XLEN-1:0]       rs_value,
    output logic [NRD*ROB_BIT-1:0]    rs_re
);

    logic [XLEN-1:0]    regs_q [NREG];
    logic [NREG-1:0]    busy_q, busy_d;
    logic [ROB_BIT-1:0] tag_q  [NREG];
    logic [ROB_BIT-1:0] tag_d  [NREG];
    logic               commit_ok, rename_ok;

    assign commit_ok = rdy_in && write_en && (reg_id != '0);
    assign rename_ok = rdy_in && reorder_en && (reorder_reg != '0) && !flush_in;

    // Ordering below gives rename priority over a colliding commit's busy clear.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        if (commit_ok && (tag_q[reg_id] == rob_id))
            busy_d[reg_id] = 1'b0;
        if (rdy_in && flush_in)
            busy_d = '0;
        if (rename_ok) begin
            busy_d[reorder_reg] = 1'b1;
            tag_d[reorder_reg]  = reorder_id;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
            if (commit_ok)
                regs_q[reg_id] <= value;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [REG_ID_BIT-1:0] addr;
        logic                  pend, byp;
        logic                  busy_o;
        logic [XLEN-1:0]       val_o;
        logic [ROB_BIT-1:0]    tag_o;

        assign addr = rs[p*REG_ID_BIT +: REG_ID_BIT];
        assign pend = (addr != '0) && busy_q[addr];
        // Bypass only while running; a paused commit has not happened yet.
        assign byp  = pend && commit_ok && (reg_id == addr) && (tag_q[addr] == rob_id);

        always_comb begin
            busy_o = 1'b0;
            val_o  = '0;
            tag_o  = '0;
            if (addr != '0) begin
                if (byp) begin
                    val_o = value;
                end else if (pend) begin
                    busy_o = 1'b1;
                    tag_o  = tag_q[addr];
                end else begin
                    val_o = regs_q[addr];
                end
            end
        end

        assign rs_busy[p]                  = busy_o;
        assign rs_value[p*XLEN +: XLEN]    = val_o;
        assign rs_re[p*ROB_BIT +: ROB_BIT] = tag_o;
    end

endmodule

// File: tb/tb_regfile_rename.sv
// Directed table-driven bench for regfile_rename (two read ports, default sizes).
module tb_regfile_rename;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, reorder_en, write_en;
    logic [4:0]  reorder_reg, reg_id;
    logic [3:0]  reorder_id, rob_id;
    logic [31:0] value;
    logic [9:0]  rs;
    logic [1:0]  rs_busy;
    logic [63:0] rs_value;
    logic [7:0]  rs_re;

    int errors = 0;
    int checks = 0;

    regfile_rename #(.XLEN(32), .NREG(32), .REG_ID_BIT(5), .ROB_BIT(4), .NRD(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .reorder_en(reorder_en), .reorder_reg(reorder_reg), .reorder_id(reorder_id),
        .write_en(write_en), .reg_id(reg_id), .rob_id(rob_id), .value(value),
        .rs(rs), .rs_busy(rs_busy), .rs_value(rs_value), .rs_re(rs_re)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rst, rdy, flush, ren;
        logic [4:0]  rreg;
        logic [3:0]  rid;
        logic        wen;
        logic [4:0]  wreg;
        logic [3:0]  wrob;
        logic [31:0] wval;
        logic [4:0]  r0, r1;
        logic        chk;
        logic [1:0]  ebusy;
        logic [31:0] ev0, ev1;
        logic [3:0]  et0, et1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic rdy, input logic flush,
        input logic ren, input logic [4:0] rreg, input logic [3:0] rid,
        input logic wen, input logic [4:0] wreg, input logic [3:0] wrob, input logic [31:0] wval,
        input logic [4:0] r0, input logic [4:0] r1, input logic chk,
        input logic [1:0] eb, input logic [31:0] ev0, input logic [31:0] ev1,
        input logic [3:0] et0, input logic [3:0] et1);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.flush = flush;
        v.ren = ren; v.rreg = rreg; v.rid = rid;
        v.wen = wen; v.wreg = wreg; v.wrob = wrob; v.wval = wval;
        v.r0 = r0; v.r1 = r1; v.chk = chk;
        v.ebusy = eb; v.ev0 = ev0; v.ev1 = ev1; v.et0 = et0; v.et1 = et1;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Drive at negedge, sample combinational reads 1ns later, state updates at next posedge.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk_in);
        rst_in = v.rst; rdy_in = v.rdy; flush_in = v.flush;
        reorder_en = v.ren; reorder_reg = v.rreg; reorder_id = v.rid;
        write_en = v.wen; reg_id = v.wreg; rob_id = v.wrob; value = v.wval;
        rs = {v.r1, v.r0};
        #1;
        if (v.chk) begin
            check("busy",  idx, {30'd0, rs_busy}, {30'd0, v.ebusy});
            check("val0",  idx, rs_value[31:0],   v.ev0);
            check("val1",  idx, rs_value[63:32],  v.ev1);
            check("tag0",  idx, {28'd0, rs_re[3:0]}, {28'd0, v.et0});
            check("tag1",  idx, {28'd0, rs_re[7:4]}, {28'd0, v.et1});
        end
        @(posedge clk_in);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; reorder_en = 1'b0; write_en = 1'b0;
        reorder_reg = '0; reorder_id = '0; reg_id = '0; rob_id = '0; value = '0; rs = '0;

        //               rst rdy fl ren rreg rid wen wreg wrob wval          r0  r1 chk eb     ev0           ev1           et0 et1
        vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,        5,  0, 0, 2'b00, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,        5,  7, 1, 2'b00, 32'h0,        32'h0,        0, 0));
        // rename then commit x5
        vecs.push_back(mk(0, 1, 0, 1, 5,  3, 0, 0,  0, 32'h0,        5,  5, 1, 2'b00, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,        5,  0, 1, 2'b01, 32'h0,        32'h0,        3, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 1, 5,  3, 32'hDEADBEEF, 5,  5, 1, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,        5,  5, 1, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0));
        // double rename of x7, stale commit keeps it busy
        vecs.push_back(mk(0, 1, 0, 1, 7,  2, 0, 0,  0, 32'h0,        7,  5, 1, 2'b00, 32'h0,        32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 7,  9, 0, 0,  0, 32'h0,        7,  7, 1, 2'b11, 32'h0,        32'h0,        2, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 1, 7,  2, 32'h11,       7,  7, 1, 2'b11, 32'h0,        32'h0,        9, 9));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,        7,  7, 1, 2'b11, 32'h0,        32'h0,        9, 9));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 1, 7,  9, 32'h22,       7,  7, 1, 2'b00, 32'h22,       32'h22,       0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,        7,  7, 1, 2'b00, 32'h22,       32'h22,       0, 0));
        // bypass, and no bypass while paused
        vecs.push_back(mk(0, 1, 0, 1, 3,  4, 0, 0,  0, 32'h0,        3,  3, 1, 2'b00, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 3,  4, 32'h55,       3,  3, 1, 2'b11, 32'h0,        32'h0,        4, 4));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 1, 3,  4, 32'h55,       3,  3, 1, 2'b00, 32'h55,       32'h55,       0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,        3,  3, 1, 2'b00, 32'h55,       32'h55,       0, 0));
        // commit/rename collision on x9
        vecs.push_back(mk(0, 1, 0, 1, 9,  1, 0, 0,  0, 32'h0,        9,  9, 1, 2'b00, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 9,  6, 1, 9,  1, 32'hA,        9,  9, 1, 2'b00, 32'hA,        32'hA,        0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,        9,  9, 1, 2'b11, 32'h0,        32'h0,        6, 6));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 1, 9,  6, 32'hB,        9,  9, 1, 2'b00, 32'hB,        32'hB,        0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,        9,  9, 1, 2'b00, 32'hB,        32'hB,        0, 0));
        // flush with simultaneous rename (dropped) and commit (kept)
        vecs.push_back(mk(0, 1, 0, 1, 1,  1, 0, 0,  0, 32'h0,        1,  2, 1, 2'b00, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 2,  2, 0, 0,  0, 32'h0,        1,  2, 1, 2'b01, 32'h0,        32'h0,        1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 31, 3, 0, 0,  0, 32'h0,        2, 31, 1, 2'b01, 32'h0,        32'h0,        2, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4,  5, 1, 2,  2, 32'h77,      31,  2, 1, 2'b01, 32'h0,        32'h77,       3, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,        1,  2, 1, 2'b00, 32'h0,        32'h77,       0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,       31,  4, 1, 2'b00, 32'h0,        32'h0,        0, 0));
        // x0 writes/renames ignored
        vecs.push_back(mk(0, 1, 0, 1, 0,  5, 1, 0,  5, 32'hFFFF,     0,  0, 1, 2'b00, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,        0,  0, 1, 2'b00, 32'h0,        32'h0,        0, 0));
        // reset with outstanding busy entries and in-flight ops
        vecs.push_back(mk(0, 1, 0, 1, 10, 8, 0, 0,  0, 32'h0,       10,  0, 1, 2'b00, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 11, 9, 0, 0,  0, 32'h0,       10, 11, 1, 2'b01, 32'h0,        32'h0,        8, 0));
        vecs.push_back(mk(1, 1, 0, 1, 12, 1, 1, 5,  0, 32'h99,      10, 11, 1, 2'b11, 32'h0,        32'h0,        8, 9));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,       10, 11, 1, 2'b00, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,        5, 12, 1, 2'b00, 32'h0,        32'h0,        0, 0));
        // rename while paused is ignored
        vecs.push_back(mk(0, 0, 0, 1, 6,  2, 0, 0,  0, 32'h0,        6,  6, 1, 2'b00, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 32'h0,        6,  6, 1, 2'b00, 32'h0,        32'h0,        0, 0));

        foreach (vecs[i]) apply(vecs[i], i);

        // Tag wrap: x20 renamed with tag 15 then tag 0; the old tag-15 commit must not free it.
        apply(mk(0, 1, 0, 1, 20, 15, 0, 0, 0, 32'h0, 20, 20, 0, 2'b00, 32'h0, 32'h0, 0, 0), 100);
        apply(mk(0, 1, 0, 1, 20, 0,  0, 0, 0, 32'h0, 20, 20, 0, 2'b00, 32'h0, 32'h0, 0, 0), 101);
        @(negedge clk_in);
        reorder_en = 1'b0; write_en = 1'b1; reg_id = 5'd20; rob_id = 4'd15; value = 32'h1;
        rs = {5'd20, 5'd20};
        #1;
        check("wrap_stale_busy", 102, {30'd0, rs_busy}, 32'd3);
        check("wrap_stale_tag",  102, {28'd0, rs_re[3:0]}, 32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        write_en = 1'b0;
        #1;
        check("wrap_held_busy", 103, {31'd0, rs_busy[1]}, 32'd1);
        check("wrap_held_val",  103, rs_value[63:32], 32'h0);
        @(posedge clk_in);
        @(negedge clk_in);
        write_en = 1'b1; reg_id = 5'd20; rob_id = 4'd0; value = 32'h2;
        @(posedge clk_in);
        @(negedge clk_in);
        write_en = 1'b0;
        #1;
        check("wrap_done_busy", 104, {30'd0, rs_busy}, 32'd0);
        check("wrap_done_val",  104, rs_value[31:0], 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
Parametrised architectural register file with rename-tag tracking for the out-of-order core. It sits between the decoder, which renames destinations and reads sources, and the ROB, which commits results. It generalises the single-port busy/tag register file with these additions:
- configurable register count, data width, tag width and number of read ports
- x0 hard-wiring
- full reset of state
- global flush on misprediction
- same-cycle commit-to-read bypass
- defined priority between commit and rename hitting the same register

Parameters:
XLEN, 32, data width of each register.
NREG, 32, number of architectural registers (power of two).
REG_ID_BIT, 5, log2(NREG).
ROB_BIT, 4, width of a ROB entry tag.
NRD, 2, number of read ports.

Ports:
clk_in  input  1  clock, all state updates on rising edge.
rst_in  input  1  synchronous reset, active-high.
rdy_in  input  1  global ready; low = pause (no state change).
flush_in  input  1  misprediction flush from ROB.
reorder_en  input  1  decoder renames a destination this cycle.
reorder_reg  input  REG_ID_BIT  destination register being renamed.
reorder_id  input  ROB_BIT  ROB tag allocated to that destination.
write_en  input  1  ROB commits a register result this cycle.
reg_id  input  REG_ID_BIT  committed destination register.
rob_id  input  ROB_BIT  ROB tag of the committing entry.
value  input  XLEN  committed data.
rs  input  NRD*REG_ID_BIT  read addresses; port i uses bits [i*REG_ID_BIT +: REG_ID_BIT].
rs_busy  output  NRD  port i: operand still pending in ROB.
rs_value  output  NRD*XLEN  port i: operand value, valid when not busy.
rs_re  output  NRD*ROB_BIT  port i: producer ROB tag, valid when busy.

Behaviour:
State:
- regs[NREG] (XLEN each), busy[NREG] (1 bit each), tag[NREG] (ROB_BIT each).

Reset:
- On a rising edge with rst_in=1, all regs, busy and tag clear to 0.
- Reset has priority over rdy_in, flush, commit and rename. Any in-flight rename or commit on that edge is discarded.
- After reset every read port outputs busy=0, value=0, tag=0.

Pause:
- With rdy_in=0 (and rst_in=0), no state changes.
- Inputs on that cycle are ignored; upstream re-presents them.
- Reads remain combinational from held state. The bypass below is disabled while paused.

Commit (rdy_in=1, write_en=1, reg_id!=0):
- regs[reg_id] <= value.
- busy[reg_id] <= 0 only if tag[reg_id]==rob_id; otherwise busy is unchanged (a younger rename owns the register).

Rename (rdy_in=1, reorder_en=1, reorder_reg!=0, flush_in=0):
- busy[reorder_reg] <= 1.
- tag[reorder_reg] <= reorder_id.

Same-register collision (commit and rename to the same register in one cycle):
- Rename wins busy and tag; the commit value is still written to regs.

Flush (rdy_in=1, flush_in=1):
- All busy bits clear to 0; tags are left as-is (don't care).
- A commit on the same cycle still writes regs. A rename on the same cycle is dropped.

x0:
- Writes and renames to register 0 are ignored.
- Register 0 always reads busy=0, value=0, tag=0.

Reads (combinational, zero latency, each port independent):
- rs==0: busy=0, value=0, tag=0.
- Else if busy[rs] and rdy_in and write_en and reg_id==rs and tag[rs]==rob_id (bypass): busy=0, value=value, tag=0.
- Else if busy[rs]: busy=1, value=0, tag=tag[rs].
- Else: busy=0, value=regs[rs], tag=0.
- A same-cycle rename does not affect reads until the next cycle. The decoder must see the old mapping for rd==rs.
- A same-cycle flush does not alter read outputs.

Tag wrap:
- Tags are compared for equality only; ROB reuse of tags is safe because a stale commit cannot match a newer tag.

Test Plan:
1. Reset -> rename x5 tag 3 -> next cycle read x5 on port 0: busy=1, tag=3, value=0. Commit x5 tag 3 value 0xDEADBEEF -> next cycle busy=0, value=0xDEADBEEF.
2. Rename x7 tag 2, then rename x7 tag 9. Commit x7 tag 2 value 0x11 -> x7 stays busy with tag 9 and regs holds 0x11. Commit tag 9 value 0x22 -> busy=0, value=0x22.
3. Bypass: x3 busy with tag 4. On the same cycle as commit x3 tag 4 value 0x55, both ports read x3 -> busy=0, value=0x55 combinationally. With rdy_in=0 on the same stimulus -> still busy with tag 4.
4. Collision: x9 busy with tag 1. Same cycle: commit x9 tag 1 value 0xA and rename x9 tag 6 -> next cycle busy=1, tag=6. Commit tag 6 value 0xB -> value 0xB.
5. Flush: rename x1, x2, x31, then flush with a simultaneous rename of x4 and commit of x2 value 0x77 -> all of x1/x2/x4/x31 read not busy, x2=0x77, x4 unchanged.
6. x0 and reset: rename x0 and commit x0 value 0xFFFF -> reads busy=0, value=0. Assert rst_in mid-sequence with busy entries outstanding -> all ports read 0/not busy on the next cycle.
